// File: rtl/btn_beep_gen_pkg.sv
// Shared definitions for the button-feedback buzzer: FSM state encoding and
// the millisecond / tone divider formulas that other ms-based timers reuse.
package btn_beep_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int MS_PER_S = 1000;

  // Clock cycles per millisecond.
  function automatic int tick_cycles(input int clk_hz);
    return clk_hz / MS_PER_S;
  endfunction

  // Clock cycles per half period of a square wave at tone_hz.
  function automatic int half_cycles(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  // Counter width able to hold 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_beep_gen_if.sv
// Event-in / buzzer-out bundle between the button logic and the beep generator.
interface btn_beep_gen_if;
  logic       i_trig;
  logic       o_buzz;
  logic       o_busy;
  logic [1:0] o_pend;
  logic       o_drop;

  modport master (
    output i_trig,
    input  o_buzz,
    input  o_busy,
    input  o_pend,
    input  o_drop
  );

  modport slave (
    input  i_trig,
    output o_buzz,
    output o_busy,
    output o_pend,
    output o_drop
  );
endinterface

// File: rtl/btn_beep_gen_tone_div.sv
// Square-wave tone divider. While enabled it toggles its output every HALF
// cycles; a clear restarts the phase with the output high so every burst
// starts identically. Disabled means silent (output low).
module btn_beep_gen_tone_div #(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tone_o
);
  import btn_beep_gen_pkg::*;

  localparam int              HW        = cnt_width(HALF);
  localparam logic [HW-1:0]   HALF_LAST = HW'(HALF - 1);

  logic [HW-1:0] cnt_q;
  logic          tone_q;

  // Half-period counter and toggling tone output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= {HW{1'b0}};
      tone_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= {HW{1'b0}};
      tone_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= {HW{1'b0}};
      tone_q <= 1'b1;
    end else if (cnt_q == HALF_LAST) begin
      cnt_q  <= {HW{1'b0}};
      tone_q <= ~tone_q;
    end else begin
      cnt_q  <= cnt_q + HW'(1);
      tone_q <= tone_q;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/btn_beep_gen.sv
// Button beep generator: each accepted trigger produces a fixed-length tone
// burst followed by a mandatory silent gap. Triggers arriving while busy are
// queued in a saturating pending counter; overflow produces a drop pulse.
module btn_beep_gen
  import btn_beep_gen_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TONE_HZ  = 2_000,
  parameter int BEEP_MS  = 100,
  parameter int GAP_MS   = 50,
  parameter int MAX_PEND = 3
) (
  input logic           clk,
  input logic           reset,
  btn_beep_gen_if.slave bus
);

  localparam int TICK   = tick_cycles(CLK_HZ);
  localparam int HALF   = half_cycles(CLK_HZ, TONE_HZ);
  localparam int MS_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
  localparam int TW     = cnt_width(TICK);
  localparam int MW     = cnt_width(MS_MAX);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [MW-1:0] BEEP_LAST = MW'(BEEP_MS - 1);
  localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
  localparam logic [1:0]    PEND_MAX  = 2'(MAX_PEND);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [MW-1:0] ms_q;
  logic [1:0]    pend_q, pend_d;
  logic          drop_q, drop_d;
  logic          busy_q;
  logic          trig;
  logic          tick_end;
  logic          beep_done;
  logic          gap_done;
  logic          tone_en;
  logic          tone_clr;
  logic          tone;

  assign trig      = bus.i_trig;
  assign tick_end  = (tick_q == TICK_LAST);
  assign beep_done = (state_q == ST_BEEP) && tick_end && (ms_q == BEEP_LAST);
  assign gap_done  = (state_q == ST_GAP)  && tick_end && (ms_q == GAP_LAST);

  // Next state, queue update and overflow detection.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_BEEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEEP, ST_GAP: begin
        if (gap_done) begin
          // A trigger landing on the dequeue cycle replaces the dequeued entry.
          if (pend_q != 2'd0) begin
            state_d = ST_BEEP;
            if (!trig) begin
              pend_d = pend_q - 2'd1;
            end else begin
              pend_d = pend_q;
            end
          end else if (trig) begin
            state_d = ST_BEEP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (beep_done) begin
            state_d = ST_GAP;
          end else begin
            state_d = state_q;
          end
          if (trig) begin
            if (pend_q < PEND_MAX) begin
              pend_d = pend_q + 2'd1;
            end else begin
              drop_d = 1'b1;
            end
          end else begin
            pend_d = pend_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 2'd0;
      end
    endcase
  end

  // FSM state plus registered busy / pending / drop outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 2'd0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Duration counters: restart on every state entry so each phase is exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= {TW{1'b0}};
      ms_q   <= {MW{1'b0}};
    end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      tick_q <= {TW{1'b0}};
      ms_q   <= {MW{1'b0}};
    end else if (tick_end) begin
      tick_q <= {TW{1'b0}};
      ms_q   <= ms_q + MW'(1);
    end else begin
      tick_q <= tick_q + TW'(1);
      ms_q   <= ms_q;
    end
  end

  // The tone runs only while the next state is BEEP and restarts on burst entry.
  assign tone_en  = (state_d == ST_BEEP);
  assign tone_clr = (state_q != ST_BEEP);

  btn_beep_gen_tone_div #(
    .HALF (HALF)
  ) u_tone_div (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tone_en),
    .clr_i  (tone_clr),
    .tone_o (tone)
  );

  assign bus.o_buzz = tone;
  assign bus.o_busy = busy_q;
  assign bus.o_pend = pend_q;
  assign bus.o_drop = drop_q;

endmodule
